// File: rtl/myo_spi_scheduler.sv
// Sweeps one shared SPI master across the motor boards of a myocontrol channel,
// streaming command RAM words out and writing received words into status RAM.
module myo_spi_scheduler #(
    parameter int unsigned NUM_MOTORS      = 8,
    parameter int unsigned WORDS_PER_FRAME = 12,
    parameter int unsigned SS_SETUP        = 4,
    parameter int unsigned SS_HOLD         = 4,
    parameter int unsigned UPDATE_PERIOD   = 50000,
    parameter int unsigned SPI_TIMEOUT     = 1024,
    localparam int unsigned MW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1,
    localparam int unsigned WW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_MOTORS-1:0] motor_mask,
    input  logic                  err_clear,
    output logic [NUM_MOTORS-1:0] ss_n,
    output logic                  spi_start,
    output logic [15:0]           spi_tx_word,
    input  logic                  spi_done,
    input  logic [15:0]           spi_rx_word,
    output logic [MW+WW-1:0]      cmd_addr,
    input  logic [15:0]           cmd_data,
    output logic                  status_we,
    output logic [MW+WW-1:0]      status_addr,
    output logic [15:0]           status_data,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    output logic                  overrun,
    output logic [NUM_MOTORS-1:0] err_flags
);

    localparam int unsigned PW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam int unsigned TW = (SPI_TIMEOUT > 1) ? $clog2(SPI_TIMEOUT) : 1;
    localparam int unsigned CMAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int unsigned CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        StIdle, StSelect, StSetup, StXfer, StWait, StStore, StHold, StFinish
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         per_q, per_d;
    logic [NUM_MOTORS-1:0] mask_q, mask_d;
    logic [MW-1:0]         m_q, m_d;
    logic [WW-1:0]         w_q, w_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         to_q, to_d;
    logic [NUM_MOTORS-1:0] ss_n_q, ss_n_d;
    logic [15:0]           tx_q, tx_d;
    logic [MW+WW-1:0]      cmd_addr_q, cmd_addr_d;
    logic [MW+WW-1:0]      st_addr_q, st_addr_d;
    logic [15:0]           st_data_q, st_data_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic [NUM_MOTORS-1:0] err_q, err_d;

    logic          tick;
    logic          found;
    logic [MW-1:0] sel;

    assign tick = enable && (per_q == PW'(UPDATE_PERIOD - 1));

    always_comb begin
        per_d = per_q;
        if (!enable || tick) begin
            per_d = '0;
        end else begin
            per_d = per_q + PW'(1);
        end
    end

    // Lowest latched-mask bit at or above the current motor index.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = int'(NUM_MOTORS) - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(m_q))) begin
                found = 1'b1;
                sel   = MW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        m_d        = m_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        ss_n_d     = ss_n_q;
        tx_d       = tx_q;
        cmd_addr_d = cmd_addr_q;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        busy_d     = busy_q;
        spi_start  = 1'b0;
        status_we  = 1'b0;
        sweep_done = 1'b0;

        // Clear first so a same-cycle set wins.
        overrun_d = err_clear ? 1'b0 : overrun_q;
        err_d     = err_clear ? '0 : err_q;
        if (tick && busy_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (tick) begin
                    mask_d  = motor_mask;
                    busy_d  = 1'b1;
                    m_d     = '0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (found && enable) begin
                    m_d        = sel;
                    w_d        = '0;
                    cnt_d      = '0;
                    ss_n_d     = ~(NUM_MOTORS'(1) << sel);
                    cmd_addr_d = {sel, WW'(0)};
                    state_d    = StSetup;
                end else begin
                    state_d = StFinish;
                end
            end
            StSetup: begin
                if (cnt_q == CW'(SS_SETUP - 1)) begin
                    tx_d    = cmd_data;
                    state_d = StXfer;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StXfer: begin
                spi_start  = 1'b1;
                cmd_addr_d = {m_q, w_q + WW'(1)};
                to_d       = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (spi_done) begin
                    st_addr_d = {m_q, w_q};
                    st_data_d = spi_rx_word;
                    state_d   = StStore;
                end else if (to_q == TW'(SPI_TIMEOUT - 1)) begin
                    err_d[m_q] = 1'b1;
                    cnt_d      = '0;
                    state_d    = StHold;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            StStore: begin
                status_we = 1'b1;
                if (w_q == WW'(WORDS_PER_FRAME - 1)) begin
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    w_d     = w_q + WW'(1);
                    tx_d    = cmd_data;
                    state_d = StXfer;
                end
            end
            StHold: begin
                if (cnt_q == CW'(SS_HOLD - 1)) begin
                    ss_n_d = '1;
                    if ((m_q == MW'(NUM_MOTORS - 1)) || !enable) begin
                        state_d = StFinish;
                    end else begin
                        m_d     = m_q + MW'(1);
                        state_d = StSelect;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StFinish: begin
                sweep_done = 1'b1;
                busy_d     = 1'b0;
                m_d        = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            per_q      <= '0;
            mask_q     <= '0;
            m_q        <= '0;
            w_q        <= '0;
            cnt_q      <= '0;
            to_q       <= '0;
            ss_n_q     <= '1;
            tx_q       <= '0;
            cmd_addr_q <= '0;
            st_addr_q  <= '0;
            st_data_q  <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            mask_q     <= mask_d;
            m_q        <= m_d;
            w_q        <= w_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            ss_n_q     <= ss_n_d;
            tx_q       <= tx_d;
            cmd_addr_q <= cmd_addr_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            err_q      <= err_d;
        end
    end

    assign ss_n        = ss_n_q;
    assign spi_tx_word = tx_q;
    assign cmd_addr    = cmd_addr_q;
    assign status_addr = st_addr_q;
    assign status_data = st_data_q;
    assign sweep_busy  = busy_q;
    assign overrun     = overrun_q;
    assign err_flags   = err_q;

endmodule
